// File: rtl/uart_alu_sequencer_pkg.sv
// Shared definitions for the UART/ALU command sequencer: state encoding and
// data/opcode width defaults common to the ALU and UART blocks.
package uart_alu_sequencer_pkg;

  localparam int unsigned DefaultNBitsData = 8;
  localparam int unsigned DefaultNBitsOp   = 6;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWaitB  = 3'd1,
    StWaitOp = 3'd2,
    StExec   = 3'd3,
    StWaitTx = 3'd4
  } state_e;

endpackage

// File: rtl/uart_alu_sequencer_timeout.sv
// Inter-byte timeout counter: counts enabled cycles and flags the terminal
// count combinationally so the caller can arbitrate it against a new byte.
module uart_timeout_counter
  import uart_alu_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned N_BITS_TMO     = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [N_BITS_TMO-1:0] TermCount = N_BITS_TMO'(TIMEOUT_CYCLES - 1);

  logic [N_BITS_TMO-1:0] count_q, count_d;

  assign terminal = enable && (count_q == TermCount);

  // Clear wins over enable; wrap to zero on the terminal count.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = terminal ? '0 : count_q + N_BITS_TMO'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_alu_sequencer.sv
// Collects operand A, operand B and opcode from the UART receiver, drives the
// ALU, then sends the ALU result back through the UART transmitter.
module uart_alu_sequencer
  import uart_alu_sequencer_pkg::*;
#(
  parameter int unsigned N_BITS_DATA    = DefaultNBitsData,
  parameter int unsigned N_BITS_OP      = DefaultNBitsOp,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned N_BITS_TMO     = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rx_done_tick_i,
  input  logic [N_BITS_DATA-1:0] rx_data_i,
  input  logic [N_BITS_DATA-1:0] alu_result_i,
  input  logic                   tx_done_tick_i,
  output logic [N_BITS_DATA-1:0] alu_a_o,
  output logic [N_BITS_DATA-1:0] alu_b_o,
  output logic [N_BITS_OP-1:0]   alu_op_o,
  output logic [N_BITS_DATA-1:0] tx_data_o,
  output logic                   tx_start_o,
  output logic                   busy_o,
  output logic                   timeout_err_o,
  output logic                   drop_o
);

  state_e state_q, state_d;

  logic [N_BITS_DATA-1:0] alu_a_q, alu_a_d;
  logic [N_BITS_DATA-1:0] alu_b_q, alu_b_d;
  logic [N_BITS_OP-1:0]   alu_op_q, alu_op_d;
  logic [N_BITS_DATA-1:0] tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   drop_q, drop_d;

  logic tmo_enable, tmo_clear, tmo_terminal;

  // Only partial commands are timed; any accepted byte restarts the window.
  assign tmo_enable = (state_q == StWaitB) || (state_q == StWaitOp);
  assign tmo_clear  = !tmo_enable || rx_done_tick_i;

  uart_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .N_BITS_TMO     (N_BITS_TMO)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .clear    (tmo_clear),
    .enable   (tmo_enable),
    .terminal (tmo_terminal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rx_done_tick_i) state_d = StWaitB;
      end
      StWaitB: begin
        if (rx_done_tick_i)    state_d = StWaitOp;
        else if (tmo_terminal) state_d = StIdle;
      end
      StWaitOp: begin
        if (rx_done_tick_i)    state_d = StExec;
        else if (tmo_terminal) state_d = StIdle;
      end
      StExec: begin
        state_d = StWaitTx;
      end
      StWaitTx: begin
        if (tx_done_tick_i) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    timeout_err_d = 1'b0;
    drop_d        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rx_done_tick_i) alu_a_d = rx_data_i;
      end
      StWaitB: begin
        if (rx_done_tick_i)    alu_b_d = rx_data_i;
        else if (tmo_terminal) timeout_err_d = 1'b1;
      end
      StWaitOp: begin
        if (rx_done_tick_i)    alu_op_d = rx_data_i[N_BITS_OP-1:0];
        else if (tmo_terminal) timeout_err_d = 1'b1;
      end
      StExec: begin
        tx_data_d  = alu_result_i;
        tx_start_d = 1'b1;
        drop_d     = rx_done_tick_i;
      end
      StWaitTx: begin
        drop_d = rx_done_tick_i;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      drop_q        <= 1'b0;
    end else begin
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      timeout_err_q <= timeout_err_d;
      drop_q        <= drop_d;
    end
  end

  assign alu_a_o       = alu_a_q;
  assign alu_b_o       = alu_b_q;
  assign alu_op_o      = alu_op_q;
  assign tx_data_o     = tx_data_q;
  assign tx_start_o    = tx_start_q;
  assign timeout_err_o = timeout_err_q;
  assign drop_o        = drop_q;
  assign busy_o        = (state_q != StIdle);

endmodule
